// File: rtl/ttt_pkg.sv
// Shared constants, FSM encoding and line tables for the tic-tac-toe
// automated player.
package ttt_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_P1    = 2'b01;
   localparam logic [1:0] CELL_P2    = 2'b10;

   localparam logic [3:0] NO_MOVE = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_THINK,
      S_DECIDE,
      S_PRESS,
      S_RELEASE
   } state_t;

   // LINES[l][j]: j-th cell of line l; l=0 is abc, l=7 is ceg
   localparam logic [7:0][2:0][3:0] LINES = {
      {4'd6, 4'd4, 4'd2},
      {4'd8, 4'd4, 4'd0},
      {4'd8, 4'd5, 4'd2},
      {4'd7, 4'd4, 4'd1},
      {4'd6, 4'd3, 4'd0},
      {4'd8, 4'd7, 4'd6},
      {4'd5, 4'd4, 4'd3},
      {4'd2, 4'd1, 4'd0}
   };

   // Fallback order: centre, corners a c g i, edges b d f h
   localparam logic [8:0][3:0] PREF = {
      4'd7, 4'd5, 4'd3, 4'd1,
      4'd8, 4'd6, 4'd2, 4'd0,
      4'd4
   };

   function automatic logic [1:0] cell_at(
      input logic [17:0] b,
      input logic [3:0]  k
   );
      return b[2*k +: 2];
   endfunction

endpackage

// File: rtl/ttt_auto_player_if.sv
// Game-side signal bundle between tic_tac_toe and the automated player.
interface ttt_auto_player_if;

   logic        enable;
   logic        p1_turn;
   logic        p2_turn;
   logic        p1_win;
   logic        p2_win;
   logic        grid_full;
   logic [17:0] board_led;
   logic [8:0]  press;
   logic [3:0]  move_idx;
   logic        busy;
   logic        ack_err;

   modport master (
      output enable, p1_turn, p2_turn,
      output p1_win, p2_win, grid_full,
      output board_led,
      input  press, move_idx, busy, ack_err
   );

   modport slave (
      input  enable, p1_turn, p2_turn,
      input  p1_win, p2_win, grid_full,
      input  board_led,
      output press, move_idx, busy, ack_err
   );

endinterface

// File: rtl/ttt_move_picker.sv
// Combinational move chooser: own win, block, centre, corners, edges.
module ttt_move_picker
   import ttt_pkg::*;
#(
   parameter int PLAYER = 2
) (
   input  logic [17:0] board,
   output logic        valid,
   output logic [3:0]  idx
);

   localparam logic [1:0] ME  = (PLAYER == 1) ? CELL_P1 : CELL_P2;
   localparam logic [1:0] OPP = (PLAYER == 1) ? CELL_P2 : CELL_P1;

   logic       win_ok, blk_ok, pref_ok;
   logic [3:0] win_k, blk_k, pref_k;
   logic [1:0] c_e, c_o1, c_o2;

   // Scan from the highest line down so the lowest qualifying one wins
   always_comb begin
      win_ok  = 1'b0;
      win_k   = '0;
      blk_ok  = 1'b0;
      blk_k   = '0;
      pref_ok = 1'b0;
      pref_k  = '0;
      c_e     = '0;
      c_o1    = '0;
      c_o2    = '0;
      for (int l = 7; l >= 0; l--) begin
         for (int j = 0; j < 3; j++) begin
            c_e  = cell_at(board, LINES[l][j]);
            c_o1 = cell_at(board, LINES[l][(j+1)%3]);
            c_o2 = cell_at(board, LINES[l][(j+2)%3]);
            if (c_e == CELL_EMPTY &&
                c_o1 == ME && c_o2 == ME) begin
               win_ok = 1'b1;
               win_k  = LINES[l][j];
            end
            if (c_e == CELL_EMPTY &&
                c_o1 == OPP && c_o2 == OPP) begin
               blk_ok = 1'b1;
               blk_k  = LINES[l][j];
            end
         end
      end
      for (int p = 8; p >= 0; p--) begin
         if (cell_at(board, PREF[p]) == CELL_EMPTY) begin
            pref_ok = 1'b1;
            pref_k  = PREF[p];
         end
      end
   end

   always_comb begin
      valid = pref_ok;
      if (win_ok)       idx = win_k;
      else if (blk_ok)  idx = blk_k;
      else if (pref_ok) idx = pref_k;
      else              idx = NO_MOVE;
   end

endmodule

// File: rtl/ttt_auto_player.sv
// Automated tic-tac-toe opponent: waits for its turn, picks a cell and
// drives a timed one-hot button press.
module ttt_auto_player
   import ttt_pkg::*;
#(
   parameter int PLAYER       = 2,
   parameter int THINK_CYCLES = 2,
   parameter int PRESS_CYCLES = 4,
   parameter int ACK_TIMEOUT  = 64
) (
   input  logic               clk,
   input  logic               reset_n,
   ttt_auto_player_if.slave   bus
);

   localparam int M1   = (THINK_CYCLES > PRESS_CYCLES) ?
                         THINK_CYCLES : PRESS_CYCLES;
   localparam int MAXC = (M1 > ACK_TIMEOUT) ? M1 : ACK_TIMEOUT;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0] THINK_LAST = CW'(THINK_CYCLES - 1);
   localparam logic [CW-1:0] PRESS_LAST = CW'(PRESS_CYCLES - 1);
   localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [8:0]      press_q, press_d;
   logic [3:0]      move_idx_q, move_idx_d;
   logic            ack_err_q, ack_err_d;

   logic            my_turn, game_over, abort;
   logic            pick_valid;
   logic [3:0]      pick_idx;

   assign my_turn   = (PLAYER == 1) ?
                      (bus.p1_turn & ~bus.p2_turn) :
                      (bus.p2_turn & ~bus.p1_turn);
   assign game_over = bus.p1_win | bus.p2_win | bus.grid_full;
   assign abort     = game_over | ~bus.enable;

   ttt_move_picker #(
      .PLAYER (PLAYER)
   ) u_picker (
      .board (bus.board_led),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         press_q    <= '0;
         move_idx_q <= NO_MOVE;
         ack_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         press_q    <= press_d;
         move_idx_q <= move_idx_d;
         ack_err_q  <= ack_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q != S_IDLE && abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.enable && my_turn && !game_over) begin
                  state_d = S_THINK;
                  cnt_d   = '0;
               end
            end
            S_THINK: begin
               if (!my_turn) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == THINK_LAST) begin
                  state_d = S_DECIDE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_DECIDE: begin
               cnt_d   = '0;
               state_d = pick_valid ? S_PRESS : S_IDLE;
            end
            S_PRESS: begin
               if (cnt_q == PRESS_LAST) begin
                  state_d = S_RELEASE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_RELEASE: begin
               // Turn passing is the game's acknowledgement
               if (!my_turn || cnt_q == ACK_LAST) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      press_d    = '0;
      move_idx_d = move_idx_q;
      if (state_d == S_PRESS) begin
         press_d = (state_q == S_DECIDE) ?
                   (9'b1 << pick_idx) : press_q;
      end
      if (state_q == S_DECIDE && state_d == S_PRESS)
         move_idx_d = pick_idx;
      ack_err_d = ack_err_q |
                  (state_q == S_RELEASE && !abort &&
                   my_turn && cnt_q == ACK_LAST);
   end

   assign bus.press    = press_q;
   assign bus.move_idx = move_idx_q;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.ack_err  = ack_err_q;

endmodule
